branch_target_buffer: RTL and testbench

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters for the pipelined LEGv8 core. It predicts taken-branch targets at fetch, learns from branches resolved in the MEM stage, and computes the mispredict/redirect decision. It also keeps saturating performance counters. This lets fetch speculate instead of always falling through until MEM resolves the branch.

---
 rtl/btb_pkg.sv | 29 ++
 rtl/branch_target_buffer_if.sv | 34 +++
 rtl/sat_counter2.sv | 23 ++
 rtl/branch_target_buffer.sv | 111 +++++++++++
 tb/tb_branch_target_buffer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// btb_pkg
// Shared definitions for the branch target buffer.
//   ctr_t            : 2-bit direction counter type
//   SNT/WNT/WT/ST    : counter states, strongly/weakly not-taken, weakly/strongly taken
//   btb_entry_t      : one table entry (valid, tag, target, ctr) at the default
//                      geometry (N=64, ENTRIES=16). Parameterised instances build the
//                      same layout with their own tag/target widths via btbEntry_t
//                      inside branch_target_buffer.
package btb_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  localparam int DEF_N     = 64;
  localparam int DEF_IDX_W = 4;
  localparam int DEF_TAG_W = DEF_N - DEF_IDX_W - 2;

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_N-1:0]     target;
    ctr_t                 ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if
// Bundles the fetch lookup, MEM-stage resolution and perf-counter signals of the BTB.
//   master : pipeline datapath side (drives pc_F, the MEM resolution and invalidate)
//   slave  : BTB side (returns prediction, mispredict/redirect and perf counters)
interface branch_target_buffer_if #(
  parameter int N     = 64,
  parameter int CNT_W = 32
);
  logic             invalidate;
  logic [N-1:0]     pc_F;
  logic             hit_F;
  logic             predTaken_F;
  logic [N-1:0]     predTarget_F;
  logic             update_M;
  logic [N-1:0]     pc_M;
  logic             taken_M;
  logic [N-1:0]     target_M;
  logic             predTaken_M;
  logic [N-1:0]     predTarget_M;
  logic             mispredict_M;
  logic [N-1:0]     redirect_M;
  logic [CNT_W-1:0] branches;
  logic [CNT_W-1:0] mispredicts;

  modport master (
    output invalidate, pc_F, update_M, pc_M, taken_M, target_M, predTaken_M, predTarget_M,
    input  hit_F, predTaken_F, predTarget_F, mispredict_M, redirect_M, branches, mispredicts
  );

  modport slave (
    input  invalidate, pc_F, update_M, pc_M, taken_M, target_M, predTaken_M, predTarget_M,
    output hit_F, predTaken_F, predTarget_F, mispredict_M, redirect_M, branches, mispredicts
  );
endinterface

// File: rtl/sat_counter2.sv
// sat_counter2
// Combinational next-state of a 2-bit saturating direction counter.
//   ctrCur : current counter value
//   inc    : 1 = branch taken (count up), 0 = not taken (count down)
//   ctrNext: next counter value, clamped at SNT and ST
module sat_counter2
  import btb_pkg::*;
(
  input  ctr_t ctrCur,
  input  logic inc,
  output ctr_t ctrNext
);

  always_comb begin
    ctrNext = ctrCur;
    if (inc) begin
      if (ctrCur != ST) ctrNext = ctrCur + 2'd1;
    end else begin
      if (ctrCur != SNT) ctrNext = ctrCur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer
// Direct-mapped BTB with 2-bit direction counters. Lookup at fetch is purely
// combinational; training happens on the clock edge from MEM-stage resolutions.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : branch_target_buffer_if.slave (lookup, resolution, mispredict, perf counters)
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int N       = 64,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_target_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = N - IDX_W - 2;

  // Same layout as btb_entry_t, sized for this instance.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [N-1:0]     target;
    ctr_t             ctr;
  } btbEntry_t;

  btbEntry_t        table_q [ENTRIES];
  logic [CNT_W-1:0] branches_q;
  logic [CNT_W-1:0] mispredicts_q;

  logic [IDX_W-1:0] idxF;
  logic [TAG_W-1:0] tagF;
  btbEntry_t        entryF;
  logic             hitF;
  logic             predTakenF;

  logic [IDX_W-1:0] idxM;
  logic [TAG_W-1:0] tagM;
  logic             hitM;
  ctr_t             ctrNextM;
  logic             mispredictM;

  // Fetch lookup: reads the table as it stands, so a same-cycle update is not bypassed.
  assign idxF       = bus.pc_F[IDX_W+1:2];
  assign tagF       = bus.pc_F[N-1:IDX_W+2];
  assign entryF     = table_q[idxF];
  assign hitF       = entryF.valid && (entryF.tag == tagF);
  assign predTakenF = hitF && entryF.ctr[1];

  assign bus.hit_F        = hitF;
  assign bus.predTaken_F  = predTakenF;
  assign bus.predTarget_F = predTakenF ? entryF.target : bus.pc_F + N'(4);

  // MEM resolution.
  assign idxM = bus.pc_M[IDX_W+1:2];
  assign tagM = bus.pc_M[N-1:IDX_W+2];
  assign hitM = table_q[idxM].valid && (table_q[idxM].tag == tagM);

  sat_counter2 u_satCounter (
    .ctrCur  (table_q[idxM].ctr),
    .inc     (bus.taken_M),
    .ctrNext (ctrNextM)
  );

  assign mispredictM = bus.update_M &&
                       ((bus.predTaken_M != bus.taken_M) ||
                        (bus.taken_M && (bus.predTarget_M != bus.target_M)));

  assign bus.mispredict_M = mispredictM;
  assign bus.redirect_M   = bus.taken_M ? bus.target_M : bus.pc_M + N'(4);
  assign bus.branches     = branches_q;
  assign bus.mispredicts  = mispredicts_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '0;
      end
    end else if (bus.invalidate) begin
      // Invalidate wins over a same-cycle update; ctr/target are left alone.
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i].valid <= 1'b0;
      end
    end else if (bus.update_M) begin
      if (hitM) begin
        table_q[idxM].ctr <= ctrNextM;
        if (bus.taken_M) table_q[idxM].target <= bus.target_M;
      end else if (bus.taken_M) begin
        table_q[idxM].valid  <= 1'b1;
        table_q[idxM].tag    <= tagM;
        table_q[idxM].target <= bus.target_M;
        table_q[idxM].ctr    <= WT;
      end
    end
  end

  // Perf counters saturate at all-ones rather than wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      if (bus.update_M && (branches_q != {CNT_W{1'b1}})) branches_q <= branches_q + 1'b1;
      if (mispredictM && (mispredicts_q != {CNT_W{1'b1}})) mispredicts_q <= mispredicts_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  localparam int N     = 64;
  localparam int ENT   = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  int   nChecks;
  int   nPass;

  branch_target_buffer_if #(.N(N), .CNT_W(CNT_W)) bus ();

  branch_target_buffer #(.N(N), .ENTRIES(ENT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per table slot, counter kept as a plain integer 0..3.
  bit          mValid  [ENT];
  logic [63:0] mTag    [ENT];
  logic [63:0] mTarget [ENT];
  int          mCtr    [ENT];
  int          mBranches;
  int          mMispredicts;

  function automatic int slotOf(input logic [63:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic logic [63:0] tagOf(input logic [63:0] pc);
    return pc >> (2 + $clog2(ENT));
  endfunction

  task automatic modelClear();
    for (int i = 0; i < ENT; i++) begin
      mValid[i] = 0; mTag[i] = '0; mTarget[i] = '0; mCtr[i] = 0;
    end
    mBranches = 0;
    mMispredicts = 0;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Drive one cycle from a negedge, check combinational outputs, clock, advance the model.
  task automatic runCycle(input logic [63:0] pcF, input bit upd, input logic [63:0] pcM,
                          input bit tk, input logic [63:0] tgt, input bit pTk,
                          input logic [63:0] pTgt, input bit inv);
    int   s;
    bit   eHit, eTk, eMis;
    logic [63:0] eTgt;
    bus.pc_F = pcF; bus.update_M = upd; bus.pc_M = pcM; bus.taken_M = tk;
    bus.target_M = tgt; bus.predTaken_M = pTk; bus.predTarget_M = pTgt; bus.invalidate = inv;
    #1;
    s    = slotOf(pcF);
    eHit = mValid[s] && (mTag[s] == tagOf(pcF));
    eTk  = eHit && (mCtr[s] >= 2);
    eTgt = eTk ? mTarget[s] : pcF + 64'd4;
    eMis = upd && ((pTk != tk) || (tk && pTgt != tgt));
    checkVal("hit_F", 64'(bus.hit_F), 64'(eHit));
    checkVal("predTaken_F", 64'(bus.predTaken_F), 64'(eTk));
    checkVal("predTarget_F", bus.predTarget_F, eTgt);
    checkVal("mispredict_M", 64'(bus.mispredict_M), 64'(eMis));
    if (eMis) checkVal("redirect_M", bus.redirect_M, tk ? tgt : pcM + 64'd4);
    checkVal("branches", 64'(bus.branches), 64'(mBranches));
    checkVal("mispredicts", 64'(bus.mispredicts), 64'(mMispredicts));
    @(posedge clk);
    if (upd && mBranches < CMAX) mBranches++;
    if (eMis && mMispredicts < CMAX) mMispredicts++;
    s = slotOf(pcM);
    if (inv) begin
      for (int i = 0; i < ENT; i++) mValid[i] = 0;
    end else if (upd) begin
      if (mValid[s] && mTag[s] == tagOf(pcM)) begin
        if (tk) begin
          mCtr[s] = (mCtr[s] < 3) ? mCtr[s] + 1 : 3;
          mTarget[s] = tgt;
        end else begin
          mCtr[s] = (mCtr[s] > 0) ? mCtr[s] - 1 : 0;
        end
      end else if (tk) begin
        mValid[s] = 1; mTag[s] = tagOf(pcM); mTarget[s] = tgt; mCtr[s] = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic lookup(input logic [63:0] pcF);
    runCycle(pcF, 0, 64'h0, 0, 64'h0, 0, 64'h0, 0);
  endtask

  function automatic logic [63:0] randPc();
    if ($urandom_range(0, 19) == 0) return 64'hFFFF_FFFF_FFFF_FFFC;
    return 64'h1000 + (64'($urandom_range(0, 3)) << 6) + (64'($urandom_range(0, 7)) << 2)
           + 64'($urandom_range(0, 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] pcA, pcB, tg;
    bit          tk, pTk, upd;
    nChecks = 0;
    nPass   = 0;
    reset = 1'b0;
    bus.pc_F = 64'h100; bus.update_M = 0; bus.pc_M = 0; bus.taken_M = 0;
    bus.target_M = 0; bus.predTaken_M = 0; bus.predTarget_M = 0; bus.invalidate = 0;
    modelClear();
    repeat (2) @(negedge clk);
    checkVal("rst hit_F", 64'(bus.hit_F), 64'd0);
    checkVal("rst predTarget_F", bus.predTarget_F, 64'h104);
    checkVal("rst branches", 64'(bus.branches), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // First taken branch at 0x100 allocates; then it predicts taken to 0x40.
    runCycle(64'h100, 1, 64'h100, 1, 64'h40, 0, 64'h0, 0);
    lookup(64'h100);
    checkVal("alloc ctr is WT", 64'(mCtr[slotOf(64'h100)]), 64'd2);
    repeat (3) runCycle(64'h100, 1, 64'h100, 0, 64'h0, 1, 64'h40, 0);
    lookup(64'h100);

    // Aliasing: 0x140 replaces 0x100 in the same slot.
    runCycle(64'h100, 1, 64'h100, 1, 64'h40, 0, 64'h0, 0);
    runCycle(64'h140, 1, 64'h140, 1, 64'h88, 0, 64'h0, 0);
    lookup(64'h100);
    lookup(64'h140);

    // Same-cycle lookup/update sees the old entry; invalidate beats update.
    runCycle(64'h200, 1, 64'h200, 1, 64'h80, 0, 64'h0, 0);
    lookup(64'h200);
    runCycle(64'h300, 1, 64'h300, 1, 64'h90, 0, 64'h0, 1);
    lookup(64'h300);
    lookup(64'h200);
    // pc+4 wraps.
    lookup(64'hFFFF_FFFF_FFFF_FFFC);

    // Random traffic; perf counters saturate along the way.
    for (int k = 0; k < 400; k++) begin
      pcA = randPc();
      pcB = ($urandom_range(0, 2) == 0) ? pcA : randPc();
      upd = ($urandom_range(0, 3) != 0);
      tk  = $urandom_range(0, 1);
      pTk = $urandom_range(0, 1);
      tg  = ($urandom_range(0, 1) != 0) ? randPc() : {$urandom(), $urandom()};
      runCycle(pcA, upd, pcB, tk, tg, pTk,
               ($urandom_range(0, 1) != 0) ? tg : randPc(),
               ($urandom_range(0, 39) == 0));
    end

    // Drive enough mispredicting updates to guarantee saturation.
    for (int k = 0; k < CMAX + 4; k++)
      runCycle(64'h100, 1, 64'h100, 1, 64'h40, 0, 64'h0, 0);
    lookup(64'h100);
    checkVal("branches sat", 64'(bus.branches), 64'(CMAX));
    checkVal("mispredicts sat", 64'(bus.mispredicts), 64'(CMAX));

    // Mid-cycle reset clears immediately and drops the in-flight update.
    bus.pc_F = 64'h100; bus.update_M = 1; bus.pc_M = 64'h100; bus.taken_M = 1;
    bus.target_M = 64'h40; bus.predTaken_M = 0; bus.predTarget_M = 0; bus.invalidate = 0;
    #2 reset = 1'b0;
    #1;
    checkVal("midrst branches", 64'(bus.branches), 64'd0);
    checkVal("midrst mispredicts", 64'(bus.mispredicts), 64'd0);
    checkVal("midrst hit_F", 64'(bus.hit_F), 64'd0);
    checkVal("midrst predTarget_F", bus.predTarget_F, 64'h104);
    @(negedge clk);
    reset = 1'b1;
    modelClear();
    lookup(64'h100);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
